// File: rtl/hazard_controller_pkg.sv
// Shared control definitions for the pipeline decoder and hazard controller.
// Contents:
//   mem_rw_e     - memory access kind carried in memory_rw_* (M_X none, M_R load, M_W store)
//   fwd_sel_e    - ALU operand source select (FWD_RF, FWD_MEM, FWD_WB)
//   mem_state_e  - data-memory wait FSM states (M_IDLE, M_WAIT)
//   WaitMax      - saturation value of the memory wait counter
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        M_X = 2'b00,
        M_R = 2'b01,
        M_W = 2'b10
    } mem_rw_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

    localparam logic [7:0] WaitMax = 8'd255;

    // Forwarding select for one ALU operand; the MEM stage holds the younger result.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       register_write_m,
        input logic [4:0] rd_w,
        input logic       register_write_w
    );
        if (register_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (register_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks an outstanding data-memory access that has not been acknowledged.
// Ports:
//   clk, reset   - pipeline clock, synchronous active-high reset
//   mem_op       - a memory access is present in the MEM stage
//   dmem_ack     - data memory completes the current access
//   mem_timeout  - sticky flag, set once an access has waited past the counter limit
module mem_wait_fsm
    import hazard_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_op,
    input  logic dmem_ack,
    output logic mem_timeout
);

    mem_state_e state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            M_IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_d    = M_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            M_WAIT: begin
                // Timeout flags the cycle after the counter has saturated.
                if (wait_cnt_q == WaitMax) begin
                    timeout_d = 1'b1;
                end
                if (dmem_ack || !mem_op) begin
                    state_d = M_IDLE;
                end else if (wait_cnt_q != WaitMax) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= M_IDLE;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stall/flush control, operand forwarding selects,
// data-memory request and stall accounting for a 5-stage in-order pipeline.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   rs1_d, rs2_d, use_rs1_d, use_rs2_d - decode-stage sources and their use flags
//   rs1_e, rs2_e                       - execute-stage sources (forwarding)
//   rd_e, register_write_e, memory_rw_e - execute-stage destination info
//   rd_m, register_write_m, memory_rw_m - memory-stage destination info
//   rd_w, register_write_w             - writeback-stage destination info
//   branch_taken_e                     - redirect resolved in execute
//   dmem_ack                           - data memory completes current access
//   pc_write, if_id_write, ex_mem_write - stage register enables
//   if_id_flush, id_ex_flush           - insert bubble into stage register
//   pc_sel                             - 1 selects branch target
//   dmem_req                           - data memory request
//   fwd_a, fwd_b                       - ALU operand source selects
//   stall_count                        - cycles with pc_write low (wraps)
//   mem_timeout                        - sticky memory timeout flag
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic        use_rs1_d,
    input  logic        use_rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        register_write_e,
    input  logic [1:0]  memory_rw_e,
    input  logic [4:0]  rd_m,
    input  logic        register_write_m,
    input  logic [1:0]  memory_rw_m,
    input  logic [4:0]  rd_w,
    input  logic        register_write_w,
    input  logic        branch_taken_e,
    input  logic        dmem_ack,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_sel,
    output logic        dmem_req,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_count,
    output logic        mem_timeout
);

    logic        mem_op_m;
    logic        mem_stall;
    logic        load_use;
    logic [31:0] stall_count_q, stall_count_d;

    assign mem_op_m  = (memory_rw_m != M_X);
    assign mem_stall = mem_op_m && !dmem_ack;
    assign load_use  = (memory_rw_e == M_R) && register_write_e && (rd_e != 5'd0) &&
                       ((use_rs1_d && (rd_e == rs1_d)) || (use_rs2_d && (rd_e == rs2_d)));

    // Priority: reset > mem_stall > branch > load-use > normal.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pc_sel       = 1'b0;
        dmem_req     = mem_op_m;
        fwd_a        = fwd_select(rs1_e, rd_m, register_write_m, rd_w, register_write_w);
        fwd_b        = fwd_select(rs2_e, rd_m, register_write_m, rd_w, register_write_w);

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            dmem_req     = 1'b0;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
        end else if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (branch_taken_e) begin
            pc_sel       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, bubble into EX; the load itself moves on to MEM.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

    mem_wait_fsm u_mem_wait_fsm (
        .clk         (clk),
        .reset       (reset),
        .mem_op      (mem_op_m),
        .dmem_ack    (dmem_ack),
        .mem_timeout (mem_timeout)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        use_rs1_d, use_rs2_d;
    logic        register_write_e, register_write_m, register_write_w;
    logic [1:0]  memory_rw_e, memory_rw_m;
    logic        branch_taken_e, dmem_ack;
    logic        pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, pc_sel;
    logic        dmem_req, mem_timeout;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    // {pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, pc_sel, dmem_req}
    logic [6:0] ctl;
    assign ctl = {pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, pc_sel,
                  dmem_req};

    localparam logic [6:0] CtlReset   = 7'b0001100;
    localparam logic [6:0] CtlNormal  = 7'b1110000;
    localparam logic [6:0] CtlLoadUse = 7'b0010100;
    localparam logic [6:0] CtlBranch  = 7'b1111110;
    localparam logic [6:0] CtlMemWait = 7'b0000001;
    localparam logic [6:0] CtlMemAck  = 7'b1110001;

    hazard_controller dut (
        .clk              (clk),
        .reset            (reset),
        .rs1_d            (rs1_d),
        .rs2_d            (rs2_d),
        .use_rs1_d        (use_rs1_d),
        .use_rs2_d        (use_rs2_d),
        .rs1_e            (rs1_e),
        .rs2_e            (rs2_e),
        .rd_e             (rd_e),
        .register_write_e (register_write_e),
        .memory_rw_e      (memory_rw_e),
        .rd_m             (rd_m),
        .register_write_m (register_write_m),
        .memory_rw_m      (memory_rw_m),
        .rd_w             (rd_w),
        .register_write_w (register_write_w),
        .branch_taken_e   (branch_taken_e),
        .dmem_ack         (dmem_ack),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .ex_mem_write     (ex_mem_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .pc_sel           (pc_sel),
        .dmem_req         (dmem_req),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_count      (stall_count),
        .mem_timeout      (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; register_write_e = 1'b0; memory_rw_e = M_X;
        rd_m = 5'd0; register_write_m = 1'b0; memory_rw_m = M_X;
        rd_w = 5'd0; register_write_w = 1'b0;
        branch_taken_e = 1'b0; dmem_ack = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        memory_rw_m = M_W;
        step();
        step();
        check("rst_ctl", 32'(ctl), 32'(CtlReset));
        check("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);

        clear_inputs();
        reset = 1'b0;
        #1;
        check("normal_ctl", 32'(ctl), 32'(CtlNormal));

        // Load-use on rs1
        memory_rw_e = M_R; register_write_e = 1'b1; rd_e = 5'd5;
        rs1_d = 5'd5; use_rs1_d = 1'b1;
        #1;
        check("load_use_ctl", 32'(ctl), 32'(CtlLoadUse));
        use_rs1_d = 1'b0;
        #1;
        check("load_use_unused_rs1", 32'(ctl), 32'(CtlNormal));
        rs2_d = 5'd5; use_rs2_d = 1'b1;
        #1;
        check("load_use_rs2", 32'(ctl), 32'(CtlLoadUse));
        rd_e = 5'd0; rs2_d = 5'd0;
        #1;
        check("load_use_x0", 32'(ctl), 32'(CtlNormal));
        rd_e = 5'd5; rs2_d = 5'd0; use_rs2_d = 1'b0; rs1_d = 5'd5; use_rs1_d = 1'b1;
        step();
        check("load_use_count", stall_count, 32'd1);
        memory_rw_e = M_X; register_write_e = 1'b0;  // load leaves EX
        #1;
        check("load_use_clears", 32'(ctl), 32'(CtlNormal));
        step();
        check("after_load_use_count", stall_count, 32'd1);

        // Branch in same cycle as load-use
        memory_rw_e = M_R; register_write_e = 1'b1; branch_taken_e = 1'b1;
        #1;
        check("branch_ctl", 32'(ctl), 32'(CtlBranch));
        step();
        check("branch_count", stall_count, 32'd1);
        clear_inputs();

        // Forwarding
        rd_m = 5'd3; rd_w = 5'd3; register_write_m = 1'b1; register_write_w = 1'b1;
        rs1_e = 5'd3; rs2_e = 5'd0;
        #1;
        check("fwd_a_mem", 32'(fwd_a), 32'(FWD_MEM));
        check("fwd_b_rf", 32'(fwd_b), 32'(FWD_RF));
        register_write_m = 1'b0;
        #1;
        check("fwd_a_wb", 32'(fwd_a), 32'(FWD_WB));
        rs2_e = 5'd3;
        #1;
        check("fwd_b_wb", 32'(fwd_b), 32'(FWD_WB));
        rd_w = 5'd0; rs1_e = 5'd0;
        #1;
        check("fwd_a_x0", 32'(fwd_a), 32'(FWD_RF));
        clear_inputs();

        // Memory wait: 4 unacknowledged cycles, then ack
        memory_rw_m = M_W;
        for (int i = 0; i < 4; i++) begin
            branch_taken_e = (i == 1);
            #1;
            check("mem_wait_ctl", 32'(ctl), 32'(CtlMemWait));
            step();
        end
        branch_taken_e = 1'b0;
        dmem_ack = 1'b1;
        #1;
        check("mem_ack_ctl", 32'(ctl), 32'(CtlMemAck));
        step();
        clear_inputs();
        #1;
        check("mem_wait_count", stall_count, 32'd5);
        check("fsm_idle", 32'(dut.u_mem_wait_fsm.state_q), 32'(M_IDLE));
        check("no_timeout_yet", 32'(mem_timeout), 32'd0);

        // Timeout
        memory_rw_m = M_R;
        repeat (250) step();
        check("timeout_early", 32'(mem_timeout), 32'd0);
        repeat (50) step();
        check("timeout_set", 32'(mem_timeout), 32'd1);
        step();
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_req", 32'(dmem_req), 32'd0);
        check("reset_in_wait_ctl", 32'(ctl), 32'(CtlReset));
        step();
        check("reset_clears_timeout", 32'(mem_timeout), 32'd0);
        check("reset_clears_count", stall_count, 32'd0);
        check("reset_fsm_idle", 32'(dut.u_mem_wait_fsm.state_q), 32'(M_IDLE));

        // Wrap: preload the counter, then two load-use stall cycles
        reset = 1'b0;
        clear_inputs();
        #1;
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        #1;
        check("wrap_preload", stall_count, 32'hFFFF_FFFE);
        memory_rw_e = M_R; register_write_e = 1'b1; rd_e = 5'd7;
        rs2_d = 5'd7; use_rs2_d = 1'b1;
        step();
        check("wrap_ffff", stall_count, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", stall_count, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-002 clk  in  1  pipeline clock, rising-edge active.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 rs1_d, rs2_d  in  5 each  decode-stage source register addresses; use_rs1_d, use_rs2_d  in  1 each  source actually read.
REQ-005 rs1_e, rs2_e  in  5 each  execute-stage source register addresses.
REQ-006 rd_e  in  5; register_write_e  in  1; memory_rw_e  in  2  execute-stage destination, write enable and memory access kind.
REQ-007 rd_m  in  5; register_write_m  in  1; memory_rw_m  in  2  memory-stage equivalents.
REQ-008 rd_w  in  5; register_write_w  in  1  writeback-stage destination and write enable.
REQ-009 branch_taken_e  in  1  resolved branch/jump redirect from execute.
REQ-010 dmem_ack  in  1  data memory completes the current access.
REQ-011 pc_write, if_id_write, ex_mem_write  out  1 each  stage register enables; if_id_flush, id_ex_flush  out  1 each  load BUBBLE.
REQ-012 pc_sel  out  1  1 = take branch target; dmem_req  out  1  data memory request.
REQ-013 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 from MEM, 10 from WB.
REQ-014 stall_count  out  32  cycles lost to any stall; mem_timeout  out  1  sticky error flag.

Function
REQ-015 mem_op_m SHALL be (memory_rw_m != M_X); dmem_req SHALL equal mem_op_m whenever reset is low.
REQ-016 mem_stall SHALL be mem_op_m && !dmem_ack: pc_write, if_id_write, ex_mem_write = 0, both flushes = 0, pc_sel = 0.
REQ-017 A load-use hazard SHALL be memory_rw_e == M_R && register_write_e && rd_e != 0 && ((use_rs1_d && rd_e == rs1_d) || (use_rs2_d && rd_e == rs2_d)).
REQ-018 On load-use (no mem_stall, no branch): pc_write = 0, if_id_write = 0, id_ex_flush = 1, ex_mem_write = 1; it clears one cycle later as the load leaves EX.
REQ-019 On branch_taken_e (no mem_stall): pc_sel = 1, if_id_flush = 1, id_ex_flush = 1, pc_write = 1; branch outranks load-use.
REQ-020 Priority SHALL be mem_stall > branch_taken_e > load-use > normal; normal = all enables 1, flushes 0, pc_sel 0.
REQ-021 fwd_a = 01 if register_write_m && rd_m != 0 && rd_m == rs1_e; else 10 if register_write_w && rd_w != 0 && rd_w == rs1_e; else 00. fwd_b uses the same rules on rs2_e; MEM outranks WB.
REQ-022 Hazard and forwarding outputs SHALL be combinational, with zero-cycle latency.
REQ-023 FSM states: M_IDLE, M_WAIT. M_IDLE -> M_WAIT when mem_stall. M_WAIT -> M_IDLE when dmem_ack or !mem_op_m. All other cases hold.
REQ-024 An 8-bit wait counter SHALL clear on entry to M_WAIT and increment each M_WAIT cycle without ack, saturating at 255.
REQ-025 mem_timeout SHALL set in the cycle after the wait counter reaches 255, and SHALL stay set until reset.
REQ-026 stall_count SHALL increment by 1 on every cycle with pc_write == 0, and SHALL wrap modulo 2^32 from 0xFFFFFFFF to 0.
REQ-027 A branch cycle with pc_write = 1 SHALL NOT count toward stall_count.

Reset
REQ-028 On reset: FSM = M_IDLE, wait counter = 0, stall_count = 0, mem_timeout = 0.
REQ-029 While reset is high: pc_write = if_id_write = ex_mem_write = 0, if_id_flush = id_ex_flush = 1, pc_sel = 0, dmem_req = 0, fwd_a = fwd_b = 00.
REQ-030 Reset asserted in M_WAIT SHALL abandon the access; dmem_req drops in that same cycle.

Structure
REQ-031 M_X=00, M_R=01, M_W=10, FWD_RF/FWD_MEM/FWD_WB and the FSM state encodings SHALL live in the shared control-definitions package used by the decoder.
REQ-032 Sub-module mem_wait_fsm SHALL contain the FSM, wait counter and mem_timeout; hazard and forwarding logic SHALL stay in the top module.

Verification
REQ-033 Load-use: memory_rw_e=M_R, register_write_e=1, rd_e=5, rs1_d=5, use_rs1_d=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_count +1.
REQ-034 Branch with load-use in the same cycle: branch_taken_e=1 -> pc_sel=1, both flushes=1, pc_write=1; stall_count unchanged.
REQ-035 Forwarding: rd_m=3, rd_w=3, both register_write=1, rs1_e=3, rs2_e=0 -> fwd_a=01, fwd_b=00; with register_write_m=0 -> fwd_a=10.
REQ-036 Memory wait: memory_rw_m=M_W, dmem_ack low 4 cycles then high -> dmem_req high 5 cycles, all enables 0 for 4 cycles, stall_count=4, FSM returns to M_IDLE.
REQ-037 Timeout: mem op held with no dmem_ack for 300 cycles -> mem_timeout=1 from wait cycle 256 onward; reset -> mem_timeout=0, dmem_req=0.
REQ-038 Wrap: stall_count forced near 0xFFFFFFFF, then 2 stall cycles -> stall_count=0x00000000.
